// File: rtl/icdir_ctl_if.sv
// icdir_ctl_if: request, response, flush and directory-port signals of the
// I-cache directory controller.
//   lkp_*   lookup request/accept (idx, tag)
//   rsp_*   one-cycle lookup result (val, hit, idx)
//   rld_*   reload write handshake; inv_* single-line invalidate handshake
//   flush_* full-invalidate request and status
//   dir_*   directory array port (read address/data, write enable/address/data)
// Modport slave is the controller; master is the requester/array side.
interface icdir_ctl_if #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 21
) ();
  logic             lkp_val;
  logic             lkp_rdy;
  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic             rsp_val;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_idx;
  logic             rld_val;
  logic             rld_rdy;
  logic [IDX_W-1:0] rld_idx;
  logic [TAG_W-1:0] rld_tag;
  logic             inv_val;
  logic             inv_rdy;
  logic [IDX_W-1:0] inv_idx;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;
  logic [IDX_W-1:0] dir_rd_adr;
  logic [TAG_W:0]   dir_rd_dat;
  logic [3:0]       dir_wr_en;
  logic [IDX_W-1:0] dir_wr_adr;
  logic [TAG_W:0]   dir_wr_dat;

  modport slave (
    input  lkp_val, lkp_idx, lkp_tag, rld_val, rld_idx, rld_tag,
           inv_val, inv_idx, flush_req, dir_rd_dat,
    output lkp_rdy, rsp_val, rsp_hit, rsp_idx, rld_rdy, inv_rdy,
           flush_busy, flush_done, dir_rd_adr, dir_wr_en, dir_wr_adr, dir_wr_dat
  );

  modport master (
    output lkp_val, lkp_idx, lkp_tag, rld_val, rld_idx, rld_tag,
           inv_val, inv_idx, flush_req, dir_rd_dat,
    input  lkp_rdy, rsp_val, rsp_hit, rsp_idx, rld_rdy, inv_rdy,
           flush_busy, flush_done, dir_rd_adr, dir_wr_en, dir_wr_adr, dir_wr_dat
  );
endinterface

// File: rtl/icdir_ctl.sv
// icdir_ctl: sequences and arbitrates the single-ported I-cache directory
// (LINES entries of {valid, tag}) between lookups, reloads, invalidates and a
// full flush sweep. Lookups take two port cycles (read address held for both,
// so async and sync arrays both work); writes take one.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  synchronous active-high reset
//   bus    icdir_ctl_if.slave (request/response/flush/directory signals)
//
// state | meaning
// IDLE  | arbitrate: flush_pend > reload > invalidate > lookup
// LKP2  | second lookup cycle: compare read data, register response
// FLUSH | write zero to line ctr each cycle, LINES cycles total
module icdir_ctl #(
  parameter int LINES        = 128,
  parameter int IDX_W        = 7,
  parameter int TAG_W        = 21,
  parameter bit FLUSH_ON_RST = 1'b1
) (
  input logic        clk_i,
  input logic        rst_i,
  icdir_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LKP2  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0] ctr_q, ctr_d;
  logic [IDX_W-1:0] lkp_idx_q, lkp_idx_d;
  logic [TAG_W-1:0] lkp_tag_q, lkp_tag_d;
  logic             rsp_val_q, rsp_val_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic             flush_done_q, flush_done_d;

  logic             lkp_rdy, rld_rdy, inv_rdy, busy;
  logic [3:0]       wr_en;
  logic [IDX_W-1:0] wr_adr, rd_adr;
  logic [TAG_W:0]   wr_dat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      flush_pend_q <= FLUSH_ON_RST;
      ctr_q        <= '0;
      lkp_idx_q    <= '0;
      lkp_tag_q    <= '0;
      rsp_val_q    <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_idx_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      ctr_q        <= ctr_d;
      lkp_idx_q    <= lkp_idx_d;
      lkp_tag_q    <= lkp_tag_d;
      rsp_val_q    <= rsp_val_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_idx_q    <= rsp_idx_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    ctr_d        = ctr_q;
    lkp_idx_d    = lkp_idx_q;
    lkp_tag_d    = lkp_tag_q;
    rsp_val_d    = 1'b0;
    rsp_hit_d    = 1'b0;
    rsp_idx_d    = rsp_idx_q;
    flush_done_d = 1'b0;
    lkp_rdy      = 1'b0;
    rld_rdy      = 1'b0;
    inv_rdy      = 1'b0;
    busy         = 1'b0;
    wr_en        = 4'h0;
    wr_adr       = '0;
    wr_dat       = '0;
    rd_adr       = lkp_idx_q;

    // A flush request seen during a sweep is absorbed by that sweep.
    if (state_q != FLUSH && bus.flush_req) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d      = FLUSH;
          ctr_d        = '0;
          flush_pend_d = 1'b0;
        end else begin
          rld_rdy = 1'b1;
          inv_rdy = !bus.rld_val;
          lkp_rdy = !bus.rld_val && !bus.inv_val;
          if (bus.rld_val) begin
            wr_en  = 4'hF;
            wr_adr = bus.rld_idx;
            wr_dat = {1'b1, bus.rld_tag};
          end else if (bus.inv_val) begin
            wr_en  = 4'hF;
            wr_adr = bus.inv_idx;
          end else if (bus.lkp_val) begin
            rd_adr    = bus.lkp_idx;
            lkp_idx_d = bus.lkp_idx;
            lkp_tag_d = bus.lkp_tag;
            state_d   = LKP2;
          end
        end
      end
      LKP2: begin
        rsp_val_d = 1'b1;
        rsp_hit_d = bus.dir_rd_dat[TAG_W] && (bus.dir_rd_dat[TAG_W-1:0] == lkp_tag_q);
        rsp_idx_d = lkp_idx_q;
        state_d   = IDLE;
      end
      FLUSH: begin
        busy   = 1'b1;
        wr_en  = 4'hF;
        wr_adr = ctr_q;
        ctr_d  = ctr_q + 1'b1;
        if (ctr_q == IDX_W'(LINES - 1)) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Keep the array port and handshakes quiet while reset is held, whatever
    // state the FSM was left in.
    if (rst_i) begin
      lkp_rdy = 1'b0;
      rld_rdy = 1'b0;
      inv_rdy = 1'b0;
      busy    = 1'b0;
      wr_en   = 4'h0;
    end
  end

  assign bus.lkp_rdy    = lkp_rdy;
  assign bus.rld_rdy    = rld_rdy;
  assign bus.inv_rdy    = inv_rdy;
  assign bus.rsp_val    = rsp_val_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_idx    = rsp_idx_q;
  assign bus.flush_busy = busy;
  assign bus.flush_done = flush_done_q;
  assign bus.dir_rd_adr = rd_adr;
  assign bus.dir_wr_en  = wr_en;
  assign bus.dir_wr_adr = wr_adr;
  assign bus.dir_wr_dat = wr_dat;

endmodule

// File: tb/tb_icdir_ctl.sv
module tb_icdir_ctl;
  localparam int IDX_W = 7;
  localparam int TAG_W = 21;
  localparam int LINES = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icdir_ctl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  icdir_ctl #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W), .FLUSH_ON_RST(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural directory array (async read).
  logic [TAG_W:0] mem [LINES];
  always @(posedge clk) if (bus.dir_wr_en == 4'hF) mem[bus.dir_wr_adr] <= bus.dir_wr_dat;
  assign bus.dir_rd_dat = mem[bus.dir_rd_adr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: directory contents as implied by accepted operations.
  bit             ref_v [LINES];
  logic [TAG_W-1:0] ref_t [LINES];

  typedef struct {
    int idx;
    bit hit;
    int cyc;
  } exp_t;
  exp_t sb[$];

  function automatic bit model_hit(int idx, logic [TAG_W-1:0] tag);
    return ref_v[idx] && (ref_t[idx] == tag);
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) ref_v[i] = 1'b0;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.rsp_val) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_idx", 32'(bus.rsp_idx), 32'(e.idx));
        check("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
        check("rsp_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rld(int idx, logic [TAG_W-1:0] tag);
    bus.rld_val = 1'b1;
    bus.rld_idx = IDX_W'(idx);
    bus.rld_tag = tag;
    @(negedge clk);
    check("rld_rdy", 32'(bus.rld_rdy), 32'd1);
    check("rld_wen", 32'(bus.dir_wr_en), 32'hF);
    check("rld_adr", 32'(bus.dir_wr_adr), 32'(idx));
    check("rld_dat", 32'(bus.dir_wr_dat), 32'({1'b1, tag}));
    step();
    bus.rld_val = 1'b0;
    ref_v[idx] = 1'b1;
    ref_t[idx] = tag;
  endtask

  task automatic do_inv(int idx);
    bus.inv_val = 1'b1;
    bus.inv_idx = IDX_W'(idx);
    @(negedge clk);
    check("inv_rdy", 32'(bus.inv_rdy), 32'd1);
    check("inv_wen", 32'(bus.dir_wr_en), 32'hF);
    check("inv_adr", 32'(bus.dir_wr_adr), 32'(idx));
    check("inv_dat", 32'(bus.dir_wr_dat), 32'd0);
    step();
    bus.inv_val = 1'b0;
    ref_v[idx] = 1'b0;
  endtask

  // Lookup plus its second cycle; a reload is offered during the second cycle
  // and must be refused. Returns one cycle into the response cycle.
  task automatic do_lkp(int idx, logic [TAG_W-1:0] tag, bit req_flush);
    exp_t e;
    bus.lkp_val = 1'b1;
    bus.lkp_idx = IDX_W'(idx);
    bus.lkp_tag = tag;
    @(negedge clk);
    check("lkp_rdy", 32'(bus.lkp_rdy), 32'd1);
    check("lkp_rd_adr", 32'(bus.dir_rd_adr), 32'(idx));
    check("lkp_wen", 32'(bus.dir_wr_en), 32'd0);
    e.idx = idx;
    e.hit = model_hit(idx, tag);
    e.cyc = cyc + 2;
    sb.push_back(e);
    step();
    bus.lkp_val   = 1'b0;
    bus.rld_val   = 1'b1;
    bus.rld_idx   = IDX_W'($urandom_range(0, LINES - 1));
    bus.flush_req = req_flush;
    @(negedge clk);
    check("lkp2_rdy", 32'({bus.lkp_rdy, bus.rld_rdy, bus.inv_rdy}), 32'd0);
    check("lkp2_rd_adr", 32'(bus.dir_rd_adr), 32'(idx));
    check("lkp2_wen", 32'(bus.dir_wr_en), 32'd0);
    step();
    bus.rld_val   = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  // Follows one flush sweep. req_at: pulse flush_req after that many lines;
  // rst_at: pulse rst after that many lines (abort). Negative disables.
  task automatic sweep(int req_at, int rst_at, output int lines, output bit done_seen);
    int  errs;
    bit  started;
    bit  aborted;
    lines = 0; errs = 0; started = 0; aborted = 0; done_seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.flush_req = 1'b0;
      if (bus.flush_busy) begin
        started = 1;
        if (bus.dir_wr_adr != IDX_W'(lines) || bus.dir_wr_dat != '0 || bus.dir_wr_en != 4'hF ||
            bus.lkp_rdy || bus.rld_rdy || bus.inv_rdy || bus.flush_done) errs++;
        lines++;
        if (lines == req_at) bus.flush_req = 1'b1;
        if (lines == rst_at) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          aborted = 1;
          break;
        end
      end else if (started) begin
        done_seen = bus.flush_done;
        break;
      end else begin
        if (bus.lkp_rdy || bus.rld_rdy || bus.inv_rdy || bus.flush_done) errs++;
      end
    end
    check("sweep_errors", 32'(errs), 32'd0);
    if (!aborted) begin
      if (done_seen) begin
        @(negedge clk);
        check("done_one_cycle", 32'(bus.flush_done), 32'd0);
      end
      step();
    end
  endtask

  task automatic lkp_burst(int n);
    exp_t e;
    bus.lkp_val = 1'b1;
    bus.lkp_idx = IDX_W'($urandom_range(0, 7));
    bus.lkp_tag = TAG_W'(21'h1ABC0 + $urandom_range(0, 3));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("b2b_rdy", 32'(bus.lkp_rdy), 32'(k % 2 == 0));
      if (bus.lkp_rdy) begin
        e.idx = int'(bus.lkp_idx);
        e.hit = model_hit(int'(bus.lkp_idx), bus.lkp_tag);
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
      step();
      if (k % 2 == 0) begin
        bus.lkp_idx = IDX_W'($urandom_range(0, 7));
        bus.lkp_tag = TAG_W'(21'h1ABC0 + $urandom_range(0, 3));
      end
    end
    bus.lkp_val = 1'b0;
    step();
  endtask

  initial begin : main
    int lines;
    bit done_seen;
    bit seen_busy;
    exp_t e;
    bus.lkp_val = 0; bus.lkp_idx = '0; bus.lkp_tag = '0;
    bus.rld_val = 0; bus.rld_idx = '0; bus.rld_tag = '0;
    bus.inv_val = 0; bus.inv_idx = '0; bus.flush_req = 0;
    for (int i = 0; i < LINES; i++) begin
      mem[i]   = (TAG_W + 1)'($urandom);
      ref_v[i] = 1'b0;
      ref_t[i] = '0;
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_val", 32'(bus.rsp_val), 32'd0);
    check("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
    check("rst_rsp_idx", 32'(bus.rsp_idx), 32'd0);
    check("rst_busy", 32'(bus.flush_busy), 32'd0);
    check("rst_done", 32'(bus.flush_done), 32'd0);
    check("rst_wen", 32'(bus.dir_wr_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Flush after reset
    sweep(-1, -1, lines, done_seen);
    check("init_sweep_lines", 32'(lines), 32'(LINES));
    check("init_sweep_done", 32'(done_seen), 32'd1);
    model_flush();

    // Reload then hit / miss
    do_rld(5, 21'h1ABCD);
    do_lkp(5, 21'h1ABCD, 1'b0);
    do_lkp(5, 21'h1ABCE, 1'b0);

    // Simultaneous rld, inv, lkp
    do_rld(11, 21'h00042);
    bus.rld_val = 1; bus.rld_idx = 7'd10; bus.rld_tag = 21'h0BEEF;
    bus.inv_val = 1; bus.inv_idx = 7'd11;
    bus.lkp_val = 1; bus.lkp_idx = 7'd10; bus.lkp_tag = 21'h0BEEF;
    @(negedge clk);
    check("pri_rld_rdy", 32'({bus.rld_rdy, bus.inv_rdy, bus.lkp_rdy}), 32'b100);
    check("pri_rld_adr", 32'(bus.dir_wr_adr), 32'd10);
    check("pri_rld_dat", 32'(bus.dir_wr_dat), 32'({1'b1, 21'h0BEEF}));
    step();
    bus.rld_val = 0; ref_v[10] = 1; ref_t[10] = 21'h0BEEF;
    @(negedge clk);
    check("pri_inv_rdy", 32'({bus.rld_rdy, bus.inv_rdy, bus.lkp_rdy}), 32'b110);
    check("pri_inv_adr", 32'(bus.dir_wr_adr), 32'd11);
    check("pri_inv_wen", 32'(bus.dir_wr_en), 32'hF);
    step();
    bus.inv_val = 0; ref_v[11] = 0;
    @(negedge clk);
    check("pri_lkp_rdy", 32'({bus.rld_rdy, bus.inv_rdy, bus.lkp_rdy}), 32'b111);
    e.idx = 10; e.hit = model_hit(10, 21'h0BEEF); e.cyc = cyc + 2;
    sb.push_back(e);
    step();
    bus.lkp_val = 0;
    step();
    do_lkp(11, 21'h00042, 1'b0);

    // Invalidate then miss
    do_inv(5);
    do_lkp(5, 21'h1ABCD, 1'b0);

    // Flush requested during LKP2; second request mid-sweep
    do_rld(3, 21'h12345);
    do_lkp(3, 21'h12345, 1'b1);
    sweep(60, -1, lines, done_seen);
    check("lkp2_sweep_lines", 32'(lines), 32'(LINES));
    check("lkp2_sweep_done", 32'(done_seen), 32'd1);
    model_flush();
    seen_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.flush_busy || bus.flush_done) seen_busy = 1;
    end
    check("no_second_flush", 32'(seen_busy), 32'd0);
    step();
    do_lkp(3, 21'h12345, 1'b0);

    // Reset mid-sweep, fresh sweep, back-to-back lookups
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    sweep(-1, 40, lines, done_seen);
    check("abort_lines", 32'(lines), 32'd40);
    sweep(-1, -1, lines, done_seen);
    check("fresh_sweep_lines", 32'(lines), 32'(LINES));
    check("fresh_sweep_done", 32'(done_seen), 32'd1);
    model_flush();
    for (int i = 0; i < 8; i++) do_rld(i, TAG_W'(21'h1ABC0 + $urandom_range(0, 3)));
    lkp_burst(6);

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: do_rld($urandom_range(0, 7), TAG_W'(21'h1ABC0 + $urandom_range(0, 3)));
        1: do_inv($urandom_range(0, 7));
        default: do_lkp($urandom_range(0, 7), TAG_W'(21'h1ABC0 + $urandom_range(0, 3)), 1'b0);
      endcase
    end

    repeat (4) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
